// File: rtl/spram_arbiter.sv
// rtl/spram_arbiter.sv - two-requester arbiter sharing one 32-bit single-port data SPRAM
// Requests are captured one at a time, then ISSUE (gnt + SPRAM cycle) and, for reads, RDATA.
module spram_arbiter #(
  parameter int AW    = 14,
  parameter bit RR_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_be,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_be,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDATA} state_t;

  state_t     state;
  logic [1:0] rst_sync;
  logic       rst_int_n;
  logic       owner;
  logic       prefer_m1;
  logic       pick_m1;

  // Assertion is immediate, release is delayed by two clocks to avoid metastable recovery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  always_comb begin
    pick_m1 = 1'b0;
    if (m1_req && !m0_req)                pick_m1 = 1'b1;
    else if (m0_req && m1_req && RR_EN)   pick_m1 = prefer_m1;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      prefer_m1 <= 1'b0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          mem_cs <= 1'b0;
          mem_we <= 1'b0;
          if (m0_req || m1_req) begin
            // The ISSUE-cycle outputs are loaded here so they are register-driven.
            state     <= ISSUE;
            owner     <= pick_m1;
            prefer_m1 <= !pick_m1;
            mem_cs    <= 1'b1;
            if (pick_m1) begin
              m1_gnt    <= 1'b1;
              mem_we    <= m1_we;
              mem_addr  <= m1_addr;
              mem_wdata <= m1_wdata;
              mem_be    <= m1_we ? m1_be : 4'b0000;
            end else begin
              m0_gnt    <= 1'b1;
              mem_we    <= m0_we;
              mem_addr  <= m0_addr;
              mem_wdata <= m0_wdata;
              mem_be    <= m0_we ? m0_be : 4'b0000;
            end
          end
        end
        ISSUE: begin
          mem_cs <= 1'b0;
          mem_we <= 1'b0;
          state  <= mem_we ? IDLE : RDATA;
        end
        RDATA: begin
          state <= IDLE;
          if (owner) begin
            m1_rdata  <= mem_rdata;
            m1_rvalid <= 1'b1;
          end else begin
            m0_rdata  <= mem_rdata;
            m0_rvalid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
